// File: rtl/tinker_pkg.sv
// Shared constants for the tinker core, its ALU and the scoreboarded register file.
package tinker_pkg;

    localparam int unsigned DATA_W   = 64;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_AW   = $clog2(NUM_REGS);
    localparam int unsigned SP_INDEX = 31;
    localparam logic [DATA_W-1:0] SP_RESET = 64'd524288;

    // Read-port offsets within an issue slot
    localparam int unsigned PORT_RS        = 0;
    localparam int unsigned PORT_RT        = 1;
    localparam int unsigned PORT_RD        = 2;
    localparam int unsigned PORTS_PER_SLOT = 3;

endpackage

// File: rtl/tinker_rf_bypass_mux.sv
// One read port: priority match of the read address against all write-back ports.
// The highest-indexed matching port wins, mirroring the array write priority.
module tinker_rf_bypass_mux #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned WB_W   = 2
) (
    input  logic [REG_AW-1:0]      addr,
    input  logic [DATA_W-1:0]      arr_data,
    input  logic [WB_W-1:0]        wb_valid,
    input  logic [WB_W*REG_AW-1:0] wb_addr,
    input  logic [WB_W*DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0]      data,
    output logic                   hit
);

    // Ascending scan so a later (higher-index) match overrides earlier ones
    always_comb begin
        data = arr_data;
        hit  = 1'b0;
        for (int k = 0; k < WB_W; k++) begin
            if (wb_valid[k] && (wb_addr[k*REG_AW +: REG_AW] == addr)) begin
                data = wb_data[k*DATA_W +: DATA_W];
                hit  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tinker_scoreboard_regfile.sv
// Multi-issue register file with per-register busy scoreboard and WB-to-read bypass.
module tinker_scoreboard_regfile #(
    parameter int unsigned       NUM_REGS = tinker_pkg::NUM_REGS,
    parameter int unsigned       DATA_W   = tinker_pkg::DATA_W,
    parameter int unsigned       ISSUE_W  = 2,
    parameter int unsigned       WB_W     = 2,
    parameter int unsigned       SP_INDEX = tinker_pkg::SP_INDEX,
    parameter logic [DATA_W-1:0] SP_RESET = tinker_pkg::SP_RESET,
    parameter int unsigned       REG_AW   = $clog2(NUM_REGS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ISSUE_W*3*REG_AW-1:0] rd_addr,
    output logic [ISSUE_W*3*DATA_W-1:0] rd_data,
    output logic [ISSUE_W*3-1:0]        rd_ready,
    input  logic [ISSUE_W-1:0]          iss_valid,
    input  logic [ISSUE_W*REG_AW-1:0]   iss_dst,
    output logic [ISSUE_W-1:0]          iss_waw,
    input  logic [WB_W-1:0]             wb_valid,
    input  logic [WB_W*REG_AW-1:0]      wb_addr,
    input  logic [WB_W*DATA_W-1:0]      wb_data,
    input  logic                        flush,
    output logic [DATA_W-1:0]           stack_pointer,
    output logic [NUM_REGS-1:0]         busy_vec
);

    import tinker_pkg::*;

    localparam int unsigned NumPorts = ISSUE_W * PORTS_PER_SLOT;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] clr, set;
    logic [NumPorts-1:0] hit;

    // Per-port bypass muxes; readiness also comes from a same-cycle write-back hit
    for (genvar p = 0; p < NumPorts; p++) begin : g_rd
        logic [REG_AW-1:0] addr;
        assign addr = rd_addr[p*REG_AW +: REG_AW];

        tinker_rf_bypass_mux #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW),
            .WB_W   (WB_W)
        ) u_mux (
            .addr     (addr),
            .arr_data (regs_q[addr]),
            .wb_valid (wb_valid),
            .wb_addr  (wb_addr),
            .wb_data  (wb_data),
            .data     (rd_data[p*DATA_W +: DATA_W]),
            .hit      (hit[p])
        );

        assign rd_ready[p] = !busy_q[addr] || hit[p];
    end

    // Scoreboard set/clear decode; issue during flush never sets a bit
    always_comb begin
        clr = '0;
        set = '0;
        for (int k = 0; k < WB_W; k++) begin
            if (wb_valid[k]) clr[wb_addr[k*REG_AW +: REG_AW]] = 1'b1;
        end
        for (int s = 0; s < ISSUE_W; s++) begin
            if (iss_valid[s] && !flush) set[iss_dst[s*REG_AW +: REG_AW]] = 1'b1;
        end
        busy_d = flush ? '0 : ((busy_q & ~clr) | set);
    end

    // WAW stall: pending producer not retiring now, or a lower slot claims the same dst
    always_comb begin
        iss_waw = '0;
        for (int s = 0; s < ISSUE_W; s++) begin
            iss_waw[s] = busy_q[iss_dst[s*REG_AW +: REG_AW]]
                       && !clr[iss_dst[s*REG_AW +: REG_AW]];
            for (int j = 0; j < s; j++) begin
                if (iss_valid[j]
                    && (iss_dst[j*REG_AW +: REG_AW] == iss_dst[s*REG_AW +: REG_AW])) begin
                    iss_waw[s] = 1'b1;
                end
            end
        end
    end

    // Array and scoreboard update; later wb ports override earlier ones on the same address
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= (r == SP_INDEX) ? SP_RESET : '0;
            end
            busy_q <= '0;
        end else begin
            for (int k = 0; k < WB_W; k++) begin
                if (wb_valid[k]) regs_q[wb_addr[k*REG_AW +: REG_AW]] <= wb_data[k*DATA_W +: DATA_W];
            end
            busy_q <= busy_d;
        end
    end

    assign stack_pointer = regs_q[SP_INDEX];
    assign busy_vec      = busy_q;

endmodule

// File: tb/tb_tinker_scoreboard_regfile.sv
// Directed self-checking bench for tinker_scoreboard_regfile.
module tb_tinker_scoreboard_regfile;

    localparam int NR = 32;
    localparam int DW = 64;
    localparam int AW = 5;
    localparam int IW = 2;
    localparam int WW = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [IW*3*AW-1:0]  rd_addr;
    logic [IW*3*DW-1:0]  rd_data;
    logic [IW*3-1:0]     rd_ready;
    logic [IW-1:0]       iss_valid;
    logic [IW*AW-1:0]    iss_dst;
    logic [IW-1:0]       iss_waw;
    logic [WW-1:0]       wb_valid;
    logic [WW*AW-1:0]    wb_addr;
    logic [WW*DW-1:0]    wb_data;
    logic                flush;
    logic [DW-1:0]       stack_pointer;
    logic [NR-1:0]       busy_vec;

    int errors = 0;
    int checks = 0;

    tinker_scoreboard_regfile dut (
        .clk           (clk),
        .reset         (reset),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_ready      (rd_ready),
        .iss_valid     (iss_valid),
        .iss_dst       (iss_dst),
        .iss_waw       (iss_waw),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .flush         (flush),
        .stack_pointer (stack_pointer),
        .busy_vec      (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ra(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic set_iss(input int s, input logic v, input logic [AW-1:0] d);
        iss_valid[s]         = v;
        iss_dst[s*AW +: AW]  = d;
    endtask

    task automatic set_wb(input int k, input logic v, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        wb_valid[k]         = v;
        wb_addr[k*AW +: AW] = a;
        wb_data[k*DW +: DW] = d;
    endtask

    function automatic logic [DW-1:0] rdat(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    task automatic idle();
        iss_valid = '0;
        wb_valid  = '0;
        flush     = 1'b0;
        reset     = 1'b0;
    endtask

    // Advance one clock, leaving inputs settled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rd_addr = '0; iss_dst = '0; wb_addr = '0; wb_data = '0;
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        set_ra(0, 5'd0); set_ra(1, 5'd1); set_ra(2, 5'd2);
        set_ra(3, 5'd31); set_ra(4, 5'd7); set_ra(5, 5'd30);
        #1;
        check("rst_busy", {32'b0, busy_vec}, 64'd0);
        check("rst_sp", stack_pointer, 64'd524288);
        check("rst_ready", {58'b0, rd_ready}, 64'h3f);
        check("rst_waw", {62'b0, iss_waw}, 64'd0);
        check("rst_r0", rdat(0), 64'd0);
        check("rst_r31", rdat(3), 64'd524288);
        check("rst_r30", rdat(5), 64'd0);

        // Issue r5, then it is not ready
        set_iss(0, 1'b1, 5'd5);
        tick();
        idle();
        set_ra(0, 5'd5);
        #1;
        check("r5_busy", {63'b0, busy_vec[5]}, 64'd1);
        check("r5_notready", {63'b0, rd_ready[0]}, 64'd0);

        // wb1 of r5 bypasses in the same cycle
        set_wb(1, 1'b1, 5'd5, 64'hDEAD);
        #1;
        check("r5_bypass", rdat(0), 64'hDEAD);
        check("r5_bypass_ready", {63'b0, rd_ready[0]}, 64'd1);
        tick();
        idle();
        #1;
        check("r5_cleared", {63'b0, busy_vec[5]}, 64'd0);
        check("r5_array", rdat(0), 64'hDEAD);

        // Two wb ports to r7: higher index wins for bypass and array
        set_wb(0, 1'b1, 5'd7, 64'h11);
        set_wb(1, 1'b1, 5'd7, 64'h22);
        set_ra(1, 5'd7);
        #1;
        check("r7_bypass", rdat(1), 64'h22);
        tick();
        idle();
        #1;
        check("r7_array", rdat(1), 64'h22);

        // r9 busy; wb r9 with a new issue to r9 in the same cycle
        set_iss(0, 1'b1, 5'd9);
        tick();
        idle();
        set_iss(0, 1'b0, 5'd9);
        #1;
        check("r9_waw_pending", {62'b0, iss_waw}, 64'd1);
        set_wb(0, 1'b1, 5'd9, 64'h99);
        set_iss(0, 1'b1, 5'd9);
        #1;
        check("r9_waw_retire", {63'b0, iss_waw[0]}, 64'd0);
        tick();
        idle();
        #1;
        check("r9_still_busy", {63'b0, busy_vec[9]}, 64'd1);

        // Both slots target r3 in the same cycle
        set_iss(0, 1'b1, 5'd3);
        set_iss(1, 1'b1, 5'd3);
        #1;
        check("r3_dual_waw", {62'b0, iss_waw}, 64'd2);
        tick();
        idle();
        #1;
        check("r3_set_once", {32'b0, busy_vec}, 64'h208);

        // r0 is writable
        set_wb(0, 1'b1, 5'd0, 64'hABC);
        tick();
        idle();
        set_ra(2, 5'd0);
        #1;
        check("r0_write", rdat(2), 64'hABC);

        // Busy r1, r2, r4 then flush with an issue to r6 and a wb to r4
        set_iss(0, 1'b1, 5'd1);
        set_iss(1, 1'b1, 5'd2);
        tick();
        idle();
        set_iss(0, 1'b1, 5'd4);
        tick();
        idle();
        #1;
        check("pre_flush_busy", {32'b0, busy_vec}, 64'h21e);
        flush = 1'b1;
        set_iss(0, 1'b1, 5'd6);
        set_wb(0, 1'b1, 5'd4, 64'h55);
        tick();
        idle();
        set_ra(3, 5'd4);
        #1;
        check("flush_busy", {32'b0, busy_vec}, 64'd0);
        check("flush_wb_r4", rdat(3), 64'h55);

        // Stack pointer updates only after the write edge
        set_wb(1, 1'b1, 5'd31, 64'h1234);
        set_ra(4, 5'd31);
        #1;
        check("sp_before", stack_pointer, 64'd524288);
        check("sp_read_bypass", rdat(4), 64'h1234);
        tick();
        idle();
        #1;
        check("sp_after", stack_pointer, 64'h1234);

        // Reset overrides concurrent issue, wb and flush
        set_iss(0, 1'b1, 5'd11);
        set_wb(0, 1'b1, 5'd10, 64'h77);
        flush = 1'b1;
        reset = 1'b1;
        tick();
        idle();
        set_ra(0, 5'd10); set_ra(1, 5'd4); set_ra(2, 5'd7);
        #1;
        check("rst2_busy", {32'b0, busy_vec}, 64'd0);
        check("rst2_r10", rdat(0), 64'd0);
        check("rst2_r4", rdat(1), 64'd0);
        check("rst2_r7", rdat(2), 64'd0);
        check("rst2_sp", stack_pointer, 64'd524288);
        check("rst2_ready", {58'b0, rd_ready}, 64'h3f);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tinker_scoreboard_regfile.md
Name: tinker_scoreboard_regfile

Overview:
Parametrised successor to the core's register file for the multi-issue tinker_core. It provides ISSUE_W issue slots with three read ports each (rs, rt, rd) and WB_W write-back ports. Per-register busy bits form a scoreboard that drives readiness and WAW stall signals. WB-to-read bypass is the same-cycle write-through path. It sits between decode/issue and the execute lanes, and replaces the stall/forwarding logic currently scattered in the core.

Parameters:
NUM_REGS, 32, number of architectural registers; address width REG_AW = $clog2(NUM_REGS)
DATA_W, 64, register width
ISSUE_W, 2, issue slots; each slot has 3 read ports and 1 destination
WB_W, 2, write-back ports
SP_INDEX, 31, stack-pointer register index
SP_RESET, 524288, reset value of register SP_INDEX

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
rd_addr  in  ISSUE_W*3*REG_AW  read addresses; port p = slot*3 + {0:rs, 1:rt, 2:rd}
rd_data  out  ISSUE_W*3*DATA_W  read data, combinational, with bypass
rd_ready  out  ISSUE_W*3  operand available (not busy, or bypassed this cycle)
iss_valid  in  ISSUE_W  slot issues an instruction that writes a register
iss_dst  in  ISSUE_W*REG_AW  destination register per slot
iss_waw  out  ISSUE_W  destination still pending; caller must stall the slot
wb_valid  in  WB_W  write-back enable per port
wb_addr  in  WB_W*REG_AW  write-back register
wb_data  in  WB_W*DATA_W  write-back value
flush  in  1  branch flush: discard all pending scoreboard entries
stack_pointer  out  DATA_W  array value of register SP_INDEX (no bypass)
busy_vec  out  NUM_REGS  registered scoreboard state, for debug and perf counters

Behaviour:
- Reset (synchronous, sampled at posedge):
  - All registers go to 0, except register SP_INDEX, which goes to SP_RESET.
  - busy_vec goes to 0.
  - The cycle after reset: rd_ready is all 1; stack_pointer = 524288; iss_waw is 0 for every slot.
  - Reset asserted mid-operation overrides flush, issue and wb in the same cycle; none of those take effect.
- Register 0 is an ordinary writable register. There is no hardwired zero.
- Reads are combinational, zero latency:
  - If any wb_valid[k] has wb_addr[k] == rd_addr, rd_data is the wb_data of the highest-indexed matching k.
  - Otherwise rd_data is the array value.
- rd_ready[p] = !busy[addr] || (some wb_valid port matches addr this cycle).
- Write: at posedge, every valid wb port writes its register.
  - Two ports writing the same address: the higher index wins.
  - This priority is identical to the bypass priority, so a bypassed read equals the next-cycle array value.
- Scoreboard next-state:
  - busy[r] = (busy[r] & ~clr[r]) | set[r].
  - clr[r] = any wb_valid to r.
  - set[r] = any iss_valid with iss_dst == r, and flush == 0.
  - set beats clr in the same cycle (new producer issued as the old one retires).
  - Two slots issuing the same dst in one cycle set the bit once.
  - There is no per-register counter; the issue stage guarantees one outstanding producer per register using iss_waw.
- iss_waw[s] = busy[iss_dst[s]] && !clr[iss_dst[s]], OR a lower slot j < s issues the same dst this cycle (iss_valid[j]).
  - iss_waw is computed regardless of iss_valid[s].
  - The caller must not assert iss_valid[s] while iss_waw[s] = 1. If it does, the busy bit is simply set again; the block does not check this.
- flush:
  - Next-cycle busy_vec is all 0.
  - Issues in the flush cycle are ignored.
  - wb writes in the flush cycle still update the array.
- stack_pointer reflects the array only; a write to SP_INDEX shows on stack_pointer the cycle after the write edge.
- No internal latency beyond one register stage; no backpressure on wb.

Decomposition:
- Shared package tinker_pkg holds: DATA_W, REG_AW, SP_INDEX, SP_RESET, and the read-port index constants PORT_RS=0, PORT_RT=1, PORT_RD=2. The core and the ALU import the same values.
- One sub-module, tinker_rf_bypass_mux: a single read port's priority match across WB_W ports, producing data and a hit flag. It is instantiated ISSUE_W*3 times with a generate loop.

Test Plan:
- Reset -> every rd_data is 0 except reading r31, which gives 524288; stack_pointer = 524288; busy_vec = 0.
- iss_valid[0]=1, iss_dst=5; next cycle read r5 -> rd_ready = 0.
  - wb_valid[1]=1, wb_addr=5, wb_data=0xDEAD in the following cycle -> same-cycle rd_data = 0xDEAD, rd_ready = 1.
  - The cycle after that -> busy_vec[5] = 0 and the array holds 0xDEAD.
- wb0 and wb1 both write r7 (0x11 and 0x22) -> bypass read = 0x22; the next-cycle array read = 0x22.
- r9 is busy; the wb of r9 and a new issue to r9 occur in the same cycle -> iss_waw = 0 and busy_vec[9] stays 1.
- Both slots iss_dst = 3 in the same cycle -> iss_waw = 2'b10.
- Set busy on r1, r2 and r4, then assert flush together with an issue to r6 -> busy_vec = 0 next cycle. A concurrent wb of 0x55 to r4 is still visible.
